// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core: captures decode fields, inserts
// load-use bubbles, squashes on taken branches and counts inserted bubbles.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Valid_D,
  input  logic [XLEN-1:0]  PC_D,
  input  logic [XLEN-1:0]  PCPlus4_D,
  input  logic [XLEN-1:0]  RD1_D,
  input  logic [XLEN-1:0]  RD2_D,
  input  logic [XLEN-1:0]  ImmExt_D,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic [4:0]       RD_D,
  input  logic             RegWrite_D,
  input  logic             MemWrite_D,
  input  logic             Jump_D,
  input  logic             Branch_D,
  input  logic             ALUSrc_D,
  input  logic [1:0]       ResultSrc_D,
  input  logic [2:0]       ALUControl_D,
  input  logic             PCSrc_E,
  input  logic             StallE,
  output logic             Valid_E,
  output logic [XLEN-1:0]  PC_E,
  output logic [XLEN-1:0]  PCPlus4_E,
  output logic [XLEN-1:0]  RD1_E,
  output logic [XLEN-1:0]  RD2_E,
  output logic [XLEN-1:0]  ImmExt_E,
  output logic [4:0]       RS1_E,
  output logic [4:0]       RS2_E,
  output logic [4:0]       RD_E,
  output logic             RegWrite_E,
  output logic             MemWrite_E,
  output logic             Jump_E,
  output logic             Branch_E,
  output logic             ALUSrc_E,
  output logic [1:0]       ResultSrc_E,
  output logic [2:0]       ALUControl_E,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic [CNT_W-1:0] BubbleCount
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic [1:0]      result_src;
    logic [2:0]      alu_ctrl;
  } ex_t;

  ex_t             ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            lu, fl;

  always_comb begin
    lu = ex_q.valid && (ex_q.result_src == 2'b01) && (ex_q.rd != 5'd0) && Valid_D &&
         ((ex_q.rd == RS1_D) || (ex_q.rd == RS2_D));
    fl = PCSrc_E & ex_q.valid;
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (!StallE) begin
      if (fl) begin
        ex_d = '0;
      end else if (lu) begin
        ex_d = '0;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      end else begin
        // Invalid D slots still pass datapath fields but can never write or redirect.
        ex_d.valid      = Valid_D;
        ex_d.pc         = PC_D;
        ex_d.pc4        = PCPlus4_D;
        ex_d.rd1        = RD1_D;
        ex_d.rd2        = RD2_D;
        ex_d.imm        = ImmExt_D;
        ex_d.rs1        = RS1_D;
        ex_d.rs2        = RS2_D;
        ex_d.rd         = RD_D;
        ex_d.reg_write  = RegWrite_D & Valid_D;
        ex_d.mem_write  = MemWrite_D & Valid_D;
        ex_d.jump       = Jump_D & Valid_D;
        ex_d.branch     = Branch_D & Valid_D;
        ex_d.alu_src    = ALUSrc_D;
        ex_d.result_src = ResultSrc_D & {2{Valid_D}};
        ex_d.alu_ctrl   = ALUControl_D;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign Valid_E      = ex_q.valid;
  assign PC_E         = ex_q.pc;
  assign PCPlus4_E    = ex_q.pc4;
  assign RD1_E        = ex_q.rd1;
  assign RD2_E        = ex_q.rd2;
  assign ImmExt_E     = ex_q.imm;
  assign RS1_E        = ex_q.rs1;
  assign RS2_E        = ex_q.rs2;
  assign RD_E         = ex_q.rd;
  assign RegWrite_E   = ex_q.reg_write;
  assign MemWrite_E   = ex_q.mem_write;
  assign Jump_E       = ex_q.jump;
  assign Branch_E     = ex_q.branch;
  assign ALUSrc_E     = ex_q.alu_src;
  assign ResultSrc_E  = ex_q.result_src;
  assign ALUControl_E = ex_q.alu_ctrl;
  assign BubbleCount  = cnt_q;

  // A flush squashes the dependent D instruction, so it overrides the interlock.
  assign StallF = StallE | (lu & ~fl);
  assign StallD = StallE | (lu & ~fl);
  assign FlushD = fl & ~StallE;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// compared against an instruction-level reference model of the EX slot.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        Valid_D, RegWrite_D, MemWrite_D, Jump_D, Branch_D, ALUSrc_D, PCSrc_E, StallE;
  logic [31:0] PC_D, PCPlus4_D, RD1_D, RD2_D, ImmExt_D;
  logic [4:0]  RS1_D, RS2_D, RD_D;
  logic [1:0]  ResultSrc_D;
  logic [2:0]  ALUControl_D;

  logic        Valid_E, RegWrite_E, MemWrite_E, Jump_E, Branch_E, ALUSrc_E;
  logic [31:0] PC_E, PCPlus4_E, RD1_E, RD2_E, ImmExt_E;
  logic [4:0]  RS1_E, RS2_E, RD_E;
  logic [1:0]  ResultSrc_E;
  logic [2:0]  ALUControl_E;
  logic        StallF, StallD, FlushD;
  logic [15:0] BubbleCount;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: the instruction currently sitting in EX
  bit          m_valid, m_rw, m_mw, m_j, m_b, m_alusrc;
  bit [31:0]   m_pc, m_pc4, m_rd1, m_rd2, m_imm;
  bit [4:0]    m_rs1, m_rs2, m_rd;
  bit [1:0]    m_rsrc;
  bit [2:0]    m_aluc;
  int          m_cnt;

  id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .Valid_D(Valid_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D),
    .RD1_D(RD1_D), .RD2_D(RD2_D), .ImmExt_D(ImmExt_D), .RS1_D(RS1_D), .RS2_D(RS2_D),
    .RD_D(RD_D), .RegWrite_D(RegWrite_D), .MemWrite_D(MemWrite_D), .Jump_D(Jump_D),
    .Branch_D(Branch_D), .ALUSrc_D(ALUSrc_D), .ResultSrc_D(ResultSrc_D),
    .ALUControl_D(ALUControl_D), .PCSrc_E(PCSrc_E), .StallE(StallE),
    .Valid_E(Valid_E), .PC_E(PC_E), .PCPlus4_E(PCPlus4_E), .RD1_E(RD1_E), .RD2_E(RD2_E),
    .ImmExt_E(ImmExt_E), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
    .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E), .Jump_E(Jump_E),
    .Branch_E(Branch_E), .ALUSrc_E(ALUSrc_E), .ResultSrc_E(ResultSrc_E),
    .ALUControl_E(ALUControl_E), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .BubbleCount(BubbleCount)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_mw = 0; m_j = 0; m_b = 0; m_alusrc = 0;
    m_pc = 0; m_pc4 = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_rsrc = 0; m_aluc = 0;
  endtask

  // D reads a register that the load now in EX has not produced yet
  function automatic bit model_load_use();
    return m_valid && (m_rsrc == 2'b01) && (m_rd != 0) && Valid_D &&
           ((m_rd == RS1_D) || (m_rd == RS2_D));
  endfunction

  function automatic bit model_flush();
    return PCSrc_E && m_valid;
  endfunction

  task automatic model_edge();
    bit fl, lu;
    fl = model_flush();
    lu = model_load_use();
    if (StallE) return;
    if (fl || lu) begin
      model_clear();
      if (!fl) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
    end else begin
      m_valid = Valid_D; m_pc = PC_D; m_pc4 = PCPlus4_D; m_rd1 = RD1_D; m_rd2 = RD2_D;
      m_imm = ImmExt_D; m_rs1 = RS1_D; m_rs2 = RS2_D; m_rd = RD_D;
      m_rw = RegWrite_D && Valid_D; m_mw = MemWrite_D && Valid_D;
      m_j = Jump_D && Valid_D; m_b = Branch_D && Valid_D;
      m_rsrc = Valid_D ? ResultSrc_D : 2'b00;
      m_alusrc = ALUSrc_D; m_aluc = ALUControl_D;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive_rand();
    Valid_D = ($urandom_range(7) != 0);
    PC_D = $urandom; PCPlus4_D = PC_D + 32'd4; RD1_D = $urandom; RD2_D = $urandom;
    ImmExt_D = $urandom;
    RS1_D = 5'($urandom_range(3)); RS2_D = 5'($urandom_range(3)); RD_D = 5'($urandom_range(3));
    RegWrite_D = 1'($urandom); MemWrite_D = 1'($urandom); Jump_D = 1'($urandom);
    Branch_D = 1'($urandom); ALUSrc_D = 1'($urandom);
    ResultSrc_D = 2'($urandom_range(2)); ALUControl_D = 3'($urandom);
    PCSrc_E = 0; StallE = 0;
  endtask

  task automatic drive_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic [1:0] rsrc);
    drive_rand();
    Valid_D = 1; PC_D = pc; PCPlus4_D = pc + 32'd4; RS1_D = rs1; RS2_D = rs2; RD_D = rd;
    RegWrite_D = 1; MemWrite_D = 0; Jump_D = 0; Branch_D = 0; ResultSrc_D = rsrc;
  endtask

  task automatic test_reset();
    #3;
    n_assert++; if (Valid_E !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", Valid_E); end
    n_assert++; if ({PC_E, PCPlus4_E, RD1_E, RD2_E, ImmExt_E} !== 160'd0) begin n_fail++; $display("FAIL reset_data got nonzero datapath"); end
    n_assert++; if ({RS1_E, RS2_E, RD_E, RegWrite_E, MemWrite_E, Jump_E, Branch_E, ALUSrc_E, ResultSrc_E, ALUControl_E} !== 25'd0) begin n_fail++; $display("FAIL reset_ctrl got nonzero control"); end
    n_assert++; if ({StallF, StallD, FlushD} !== 3'b000) begin n_fail++; $display("FAIL reset_hazard got %b want 000", {StallF, StallD, FlushD}); end
    n_assert++; if (BubbleCount !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", BubbleCount); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_normal_flow();
    drive_instr(32'h100, 5'd3, 5'd0, 5'd5, 2'b00);
    #1;
    n_assert++; if ({StallF, StallD, FlushD} !== 3'b000) begin n_fail++; $display("FAIL normal_hazard got %b want 000", {StallF, StallD, FlushD}); end
    step();
    Valid_D = 0;
    #1;
    n_assert++; if (PC_E !== 32'h100) begin n_fail++; $display("FAIL normal_pc got %h want 100", PC_E); end
    n_assert++; if ({RS1_E, RD_E} !== {5'd3, 5'd5}) begin n_fail++; $display("FAIL normal_regs got rs1=%0d rd=%0d want 3 5", RS1_E, RD_E); end
    n_assert++; if ({Valid_E, RegWrite_E} !== 2'b11) begin n_fail++; $display("FAIL normal_valid got %b want 11", {Valid_E, RegWrite_E}); end
    n_assert++; if ({StallF, StallD, FlushD} !== 3'b000) begin n_fail++; $display("FAIL normal_hazard2 got %b want 000", {StallF, StallD, FlushD}); end
  endtask

  task automatic test_load_use();
    drive_instr(32'h104, 5'd1, 5'd2, 5'd7, 2'b01);
    #1; step();
    drive_instr(32'h108, 5'd1, 5'd7, 5'd8, 2'b00);
    #1;
    n_assert++; if ({StallF, StallD, FlushD} !== 3'b110) begin n_fail++; $display("FAIL lu_stall got %b want 110", {StallF, StallD, FlushD}); end
    n_assert++; if (BubbleCount !== 16'd0) begin n_fail++; $display("FAIL lu_count_before got %0d want 0", BubbleCount); end
    step(); #1;
    n_assert++; if ({Valid_E, RegWrite_E, RD_E} !== 7'd0) begin n_fail++; $display("FAIL lu_bubble got v=%b rw=%b rd=%0d want 0", Valid_E, RegWrite_E, RD_E); end
    n_assert++; if (BubbleCount !== 16'd1) begin n_fail++; $display("FAIL lu_count got %0d want 1", BubbleCount); end
    n_assert++; if (StallF !== 1'b0) begin n_fail++; $display("FAIL lu_release got %b want 0", StallF); end
    step(); #1;
    n_assert++; if ({Valid_E, PC_E, RS2_E} !== {1'b1, 32'h108, 5'd7}) begin n_fail++; $display("FAIL lu_capture got v=%b pc=%h rs2=%0d want 1 108 7", Valid_E, PC_E, RS2_E); end
  endtask

  task automatic test_branch_flush();
    int cnt0;
    drive_rand(); PCSrc_E = 1;
    #1;
    n_assert++; if ({StallF, FlushD} !== 2'b01) begin n_fail++; $display("FAIL br_flush got stall=%b flush=%b want 0 1", StallF, FlushD); end
    step(); #1;
    n_assert++; if ({Valid_E, RegWrite_E, MemWrite_E, Jump_E, Branch_E} !== 5'd0) begin n_fail++; $display("FAIL br_bubble got %b want 00000", {Valid_E, RegWrite_E, MemWrite_E, Jump_E, Branch_E}); end
    drive_instr(32'h200, 5'd1, 5'd2, 5'd12, 2'b01);
    #1; step();
    drive_instr(32'h204, 5'd12, 5'd0, 5'd3, 2'b00); PCSrc_E = 1;
    cnt0 = m_cnt;
    #1;
    n_assert++; if ({StallF, StallD, FlushD} !== 3'b001) begin n_fail++; $display("FAIL br_lu_hazard got %b want 001", {StallF, StallD, FlushD}); end
    step(); #1;
    n_assert++; if (Valid_E !== 1'b0) begin n_fail++; $display("FAIL br_lu_valid got %b want 0", Valid_E); end
    n_assert++; if (BubbleCount !== 16'(cnt0)) begin n_fail++; $display("FAIL br_lu_count got %0d want %0d", BubbleCount, cnt0); end
  endtask

  task automatic test_back_pressure();
    drive_instr(32'h300, 5'd1, 5'd2, 5'd4, 2'b00);
    #1; step();
    for (int i = 0; i < 3; i++) begin
      drive_rand(); StallE = 1; PCSrc_E = 1;
      #1;
      n_assert++; if ({StallF, StallD, FlushD} !== 3'b110) begin n_fail++; $display("FAIL bp_hazard[%0d] got %b want 110", i, {StallF, StallD, FlushD}); end
      step(); #1;
      n_assert++; if ({Valid_E, PC_E, RD_E, RegWrite_E} !== {1'b1, 32'h300, 5'd4, 1'b1}) begin n_fail++; $display("FAIL bp_hold[%0d] got v=%b pc=%h rd=%0d want 1 300 4", i, Valid_E, PC_E, RD_E); end
    end
    drive_rand(); PCSrc_E = 1;
    #1;
    n_assert++; if (FlushD !== 1'b1) begin n_fail++; $display("FAIL bp_flush_release got %b want 1", FlushD); end
    step(); #1;
    n_assert++; if (Valid_E !== 1'b0) begin n_fail++; $display("FAIL bp_flush_bubble got %b want 0", Valid_E); end
  endtask

  task automatic test_x0_load();
    drive_instr(32'h400, 5'd1, 5'd2, 5'd0, 2'b01);
    #1; step();
    drive_instr(32'h404, 5'd0, 5'd0, 5'd6, 2'b00);
    #1;
    n_assert++; if (StallF !== 1'b0) begin n_fail++; $display("FAIL x0_stall got %b want 0", StallF); end
    step(); #1;
    n_assert++; if ({Valid_E, PC_E} !== {1'b1, 32'h404}) begin n_fail++; $display("FAIL x0_capture got v=%b pc=%h want 1 404", Valid_E, PC_E); end
  endtask

  task automatic test_saturation();
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 65535;
    drive_instr(32'h500, 5'd1, 5'd2, 5'd9, 2'b01);
    #1; step();
    drive_instr(32'h504, 5'd9, 5'd1, 5'd3, 2'b00);
    #1;
    n_assert++; if (StallF !== 1'b1) begin n_fail++; $display("FAIL sat_stall got %b want 1", StallF); end
    step(); #1;
    n_assert++; if (BubbleCount !== 16'hFFFF) begin n_fail++; $display("FAIL sat_count got %h want ffff", BubbleCount); end
  endtask

  task automatic test_random();
    bit st, fs;
    for (int i = 0; i < 400; i++) begin
      drive_rand();
      PCSrc_E = ($urandom_range(7) == 0);
      StallE  = ($urandom_range(5) == 0);
      #1;
      st = StallE || (model_load_use() && !model_flush());
      fs = model_flush() && !StallE;
      n_assert++; if ({StallF, StallD, FlushD} !== {st, st, fs}) begin n_fail++; $display("FAIL rnd_hazard[%0d] got %b want %b", i, {StallF, StallD, FlushD}, {st, st, fs}); end
      n_assert++; if ({Valid_E, PC_E, PCPlus4_E, RD1_E, RD2_E, ImmExt_E} !== {m_valid, m_pc, m_pc4, m_rd1, m_rd2, m_imm}) begin n_fail++; $display("FAIL rnd_data[%0d] got v=%b pc=%h want v=%b pc=%h", i, Valid_E, PC_E, m_valid, m_pc); end
      n_assert++; if ({RS1_E, RS2_E, RD_E, RegWrite_E, MemWrite_E, Jump_E, Branch_E, ResultSrc_E} !== {m_rs1, m_rs2, m_rd, m_rw, m_mw, m_j, m_b, m_rsrc}) begin n_fail++; $display("FAIL rnd_ctrl[%0d] got rd=%0d rw=%b rs=%b want rd=%0d rw=%b rs=%b", i, RD_E, RegWrite_E, ResultSrc_E, m_rd, m_rw, m_rsrc); end
      if (m_valid) begin
        n_assert++; if ({ALUSrc_E, ALUControl_E} !== {m_alusrc, m_aluc}) begin n_fail++; $display("FAIL rnd_alu[%0d] got %b want %b", i, {ALUSrc_E, ALUControl_E}, {m_alusrc, m_aluc}); end
      end
      n_assert++; if (BubbleCount !== 16'(m_cnt)) begin n_fail++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, BubbleCount, m_cnt); end
      step();
    end
  endtask

  task automatic test_async_reset();
    drive_instr(32'h600, 5'd1, 5'd2, 5'd11, 2'b01);
    #1; step();
    drive_instr(32'h604, 5'd11, 5'd2, 5'd3, 2'b00);
    #1;
    n_assert++; if (StallF !== 1'b1) begin n_fail++; $display("FAIL ar_pre_stall got %b want 1", StallF); end
    #2;
    rst = 1;
    #1;
    model_clear(); m_cnt = 0;
    n_assert++; if ({Valid_E, RegWrite_E} !== 2'b00) begin n_fail++; $display("FAIL ar_state got %b want 00", {Valid_E, RegWrite_E}); end
    n_assert++; if (BubbleCount !== 16'd0) begin n_fail++; $display("FAIL ar_count got %0d want 0", BubbleCount); end
    n_assert++; if (StallF !== 1'b0) begin n_fail++; $display("FAIL ar_stall got %b want 0", StallF); end
    @(negedge clk);
    rst = 0;
    drive_instr(32'h700, 5'd2, 5'd3, 5'd4, 2'b00);
    #1; step(); #1;
    n_assert++; if ({Valid_E, PC_E, RD_E} !== {1'b1, 32'h700, 5'd4}) begin n_fail++; $display("FAIL ar_after got v=%b pc=%h rd=%0d want 1 700 4", Valid_E, PC_E, RD_E); end
  endtask

  initial begin
    rst = 1;
    drive_rand();
    Valid_D = 0;
    model_clear();
    m_cnt = 0;
    test_reset();
    test_normal_flow();
    test_load_use();
    test_branch_flush();
    test_back_pressure();
    test_x0_load();
    test_saturation();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
